// File: rtl/set_job_sequencer_pkg.sv
// Shared definitions for the SET job sequencer: mode codes, payload field
// widths, the packed job record and the sequencer FSM state codes.
package set_pkg;

  // Job modes understood by SET.
  localparam logic [1:0] MODE_SINGLE    = 2'b00;
  localparam logic [1:0] MODE_UNION     = 2'b01;
  localparam logic [1:0] MODE_DIFF      = 2'b10;
  localparam logic [1:0] MODE_INTERSECT = 2'b11;

  // Each coordinate and each radius is a 4-bit field.
  localparam int CENTRAL_FW = 4;
  localparam int RADIUS_FW  = 4;
  localparam int CENTRAL_W  = 6 * CENTRAL_FW;  // {x1,y1,x2,y2,x3,y3}
  localparam int RADIUS_W   = 3 * RADIUS_FW;   // {r1,r2,r3}

  // Payload handed to SET; travels through the FIFO bit-exact.
  typedef struct packed {
    logic [CENTRAL_W-1:0] central;
    logic [RADIUS_W-1:0]  radius;
    logic [1:0]           mode;
  } job_t;

  // Sequencer FSM state enumeration (kept as plain constants so older
  // tools and waveform scripts see fixed codes).
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

endpackage

// File: rtl/set_job_sequencer_fifo.sv
// set_job_fifo: synchronous FIFO with occupancy count. DEPTH must be a power
// of two (>= 2) so the pointers wrap naturally. Head data is read
// combinationally from the read pointer.
module set_job_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == (AW+1)'(0));
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= (AW+1)'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/set_job_sequencer.sv
// set_job_sequencer: buffers (central, radius, mode, tag) jobs, issues them
// one at a time to SET with a one-cycle en pulse, captures the candidate and
// returns it tagged on a valid/ready result port.
// Optional watchdog: define SEQ_TIMEOUT_EN to abort a WAIT after
// TIMEOUT_CYCLES cycles with res_timeout=1 and res_candidate=8'hFF.
module set_job_sequencer
  import set_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TAG_W          = 6,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [CENTRAL_W-1:0] job_central,
  input  logic [RADIUS_W-1:0]  job_radius,
  input  logic [1:0]           job_mode,
  input  logic [TAG_W-1:0]     job_tag,
  output logic                 set_en,
  output logic [CENTRAL_W-1:0] set_central,
  output logic [RADIUS_W-1:0]  set_radius,
  output logic [1:0]           set_mode,
  input  logic                 set_busy,
  input  logic                 set_valid,
  input  logic [7:0]           set_candidate,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [7:0]           res_candidate,
  output logic [TAG_W-1:0]     res_tag,
  output logic [1:0]           res_mode,
  output logic                 res_timeout,
  output logic                 idle
);

  localparam int FW  = $bits(job_t) + TAG_W;
  localparam int CNW = $clog2(DEPTH) + 1;

  job_t                 in_job_s;
  job_t                 head_job_s;
  logic [TAG_W-1:0]     head_tag_s;
  logic [FW-1:0]        fifo_rdata_s;
  logic [CNW-1:0]       fifo_count_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;

  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic                 pop_s;
  logic                 capture_s;
  logic                 timeout_s;

  logic                 set_en_q;
  logic [CENTRAL_W-1:0] set_central_q;
  logic [RADIUS_W-1:0]  set_radius_q;
  logic [1:0]           set_mode_q;
  logic                 res_valid_q;
  logic [7:0]           res_candidate_q;
  logic [TAG_W-1:0]     res_tag_q;
  logic [1:0]           res_mode_q;

  assign in_job_s.central = job_central;
  assign in_job_s.radius  = job_radius;
  assign in_job_s.mode    = job_mode;
  assign {head_tag_s, head_job_s} = fifo_rdata_s;

  set_job_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (job_valid),
    .wdata_i ({job_tag, in_job_s}),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .count_o (fifo_count_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign job_ready     = (fifo_count_s < CNW'(DEPTH));
  assign idle          = fifo_empty_s && (state_q == ST_IDLE);
  assign set_en        = set_en_q;
  assign set_central   = set_central_q;
  assign set_radius    = set_radius_q;
  assign set_mode      = set_mode_q;
  assign res_valid     = res_valid_q;
  assign res_candidate = res_candidate_q;
  assign res_tag       = res_tag_q;
  assign res_mode      = res_mode_q;

`ifdef SEQ_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        tmo_hit_s;
  logic        res_timeout_q;

  assign tmo_hit_s   = (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign res_timeout = res_timeout_q;

  // Watchdog counter: zeroed on the way into WAIT, counts each WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= 16'd0;
    end else if (state_q == ST_ISSUE) begin
      tmo_cnt_q <= 16'd0;
    end else if (state_q == ST_WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  // Abort flag: set by a watchdog expiry, cleared by a real result or a new issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_timeout_q <= 1'b0;
    end else if (timeout_s) begin
      res_timeout_q <= 1'b1;
    end else if (capture_s || pop_s) begin
      res_timeout_q <= 1'b0;
    end
  end
`else
  logic [31:0] unused_timeout_cycles_s;

  assign unused_timeout_cycles_s = 32'(TIMEOUT_CYCLES);
  assign res_timeout             = 1'b0;
`endif

  // FSM next state plus the pop / capture / timeout strobes.
  always_comb begin
    state_d   = state_q;
    pop_s     = 1'b0;
    capture_s = 1'b0;
    timeout_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s && !set_busy) begin
          pop_s   = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A real result beats a watchdog expiry landing in the same cycle.
        if (set_valid) begin
          capture_s = 1'b1;
          state_d   = ST_RESULT;
`ifdef SEQ_TIMEOUT_EN
        end else if (tmo_hit_s) begin
          timeout_s = 1'b1;
          state_d   = ST_RESULT;
`endif
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, SET-side registers and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      set_en_q        <= 1'b0;
      set_central_q   <= '0;
      set_radius_q    <= '0;
      set_mode_q      <= 2'b00;
      res_valid_q     <= 1'b0;
      res_candidate_q <= 8'd0;
      res_tag_q       <= '0;
      res_mode_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      set_en_q    <= pop_s;
      res_valid_q <= (state_d == ST_RESULT);
      if (pop_s) begin
        set_central_q <= head_job_s.central;
        set_radius_q  <= head_job_s.radius;
        set_mode_q    <= head_job_s.mode;
        res_tag_q     <= head_tag_s;
        res_mode_q    <= head_job_s.mode;
      end
      if (capture_s) begin
        res_candidate_q <= set_candidate;
      end else if (timeout_s) begin
        res_candidate_q <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_set_job_sequencer.sv
// Self-checking bench for set_job_sequencer: a stub SET, a scoreboard queue
// filled at job acceptance and a monitor that drains it on each result
// handshake. Define SEQ_TIMEOUT_EN to also exercise the watchdog.
module tb_set_job_sequencer;

`ifdef SEQ_TIMEOUT_EN
  localparam int TB_TMO = 16;
`else
  localparam int TB_TMO = 4096;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [23:0] job_central = 24'd0;
  logic [11:0] job_radius = 12'd0;
  logic [1:0]  job_mode = 2'd0;
  logic [5:0]  job_tag = 6'd0;
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy = 1'b0;
  logic        set_valid = 1'b0;
  logic [7:0]  set_candidate = 8'd0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [7:0]  res_candidate;
  logic [5:0]  res_tag;
  logic [1:0]  res_mode;
  logic        res_timeout;
  logic        idle;

  set_job_sequencer #(.DEPTH(4), .TAG_W(6), .TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_central(job_central), .job_radius(job_radius), .job_mode(job_mode),
    .job_tag(job_tag), .set_en(set_en), .set_central(set_central),
    .set_radius(set_radius), .set_mode(set_mode), .set_busy(set_busy),
    .set_valid(set_valid), .set_candidate(set_candidate), .res_valid(res_valid),
    .res_ready(res_ready), .res_candidate(res_candidate), .res_tag(res_tag),
    .res_mode(res_mode), .res_timeout(res_timeout), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cand;
    logic [5:0] tag;
    logic [1:0] mode;
    logic       tmo;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   push_cyc, en_cyc, vld_cyc, rise_cyc;
  int   en_count = 0;
  int   res_count = 0;
  bit   stub_force = 0;
  bit   stub_never = 0;
  bit   stub_rand = 0;
  int   stub_delay = 5;
  logic [7:0] stub_force_val = 8'd0;
  bit   rr_rand = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Candidate the stub SET reports for a job: a fingerprint of every payload bit.
  function automatic logic [7:0] model_cand(logic [23:0] c, logic [11:0] r, logic [1:0] m);
    return c[7:0] ^ c[15:8] ^ c[23:16] ^ r[7:0] ^ {r[11:8], 2'b01, m};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Offer one job for up to budget cycles; record the expected result if taken.
  task automatic push_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                          input logic [5:0] t, input int budget, output bit accepted);
    exp_t e;
    bit   ok;
    accepted = 1'b0;
    @(posedge clk); #1;
    job_valid = 1'b1; job_central = c; job_radius = r; job_mode = m; job_tag = t;
    for (int i = 0; i < budget && !accepted; i++) begin
      @(negedge clk); ok = job_ready;
      @(posedge clk); if (ok) accepted = 1'b1;
    end
    #1;
    push_cyc = cyc;
    job_valid = 1'b0;
    if (accepted) begin
      e.cand = stub_never ? 8'hFF : (stub_force ? stub_force_val : model_cand(c, r, m));
      e.tag = t; e.mode = m; e.tmo = stub_never;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_ok(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                         input logic [5:0] t);
    bit acc;
    push_job(c, r, m, t, 200, acc);
    chk("push_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && idle) break;
    end
    chk("drain_results_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Stub SET: answers each en pulse after a delay with the job's fingerprint.
  initial begin
    logic [7:0] cand;
    int d;
    forever begin
      @(negedge clk);
      if (set_en && !rst && !stub_never) begin
        cand = stub_force ? stub_force_val : model_cand(set_central, set_radius, set_mode);
        d = stub_rand ? int'($urandom_range(30, 1)) : stub_delay;
        repeat (d) @(posedge clk);
        #1; set_valid = 1'b1; set_candidate = cand; vld_cyc = cyc;
        @(posedge clk); #1; set_valid = 1'b0; set_candidate = 8'($urandom);
      end
    end
  end

  // en pulse watcher: counts pulses, timestamps them, rejects two-cycle pulses.
  initial begin
    bit prev_en = 0;
    forever begin
      @(negedge clk);
      if (!rst && set_en) begin
        en_count++; en_cyc = cyc;
        chk("set_en_one_cycle", 32'(prev_en), 32'd0);
      end
      prev_en = set_en;
    end
  end

  // Random consumer backpressure when enabled.
  initial forever begin
    @(posedge clk); #1;
    if (rr_rand) res_ready = 1'($urandom_range(1, 0));
  end

  // Result monitor: holds stability under backpressure, pops scoreboard on handshake.
  initial begin
    bit hold = 0;
    bit prev_valid = 0;
    logic [16:0] hold_pl;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0; prev_valid = 0;
      end else begin
        if (hold) begin
          chk("hold_res_valid", 32'(res_valid), 32'd1);
          chk("hold_payload", 32'({res_candidate, res_tag, res_mode, res_timeout}), 32'(hold_pl));
        end
        if (res_valid && !prev_valid) rise_cyc = cyc;
        if (res_valid && res_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_result: actual tag=%0d required=no result", res_tag);
          end else begin
            e = exp_q.pop_front();
            tests--;
            chk("res_candidate", 32'(res_candidate), 32'(e.cand));
            chk("res_tag", 32'(res_tag), 32'(e.tag));
            chk("res_mode", 32'(res_mode), 32'(e.mode));
            chk("res_timeout", 32'(res_timeout), 32'(e.tmo));
            res_count++;
          end
        end
        hold = res_valid && !res_ready;
        hold_pl = {res_candidate, res_tag, res_mode, res_timeout};
        prev_valid = res_valid;
      end
    end
  end

  initial begin
    bit acc;
    int en_before, cnt_before, late_bad;

    // Reset values.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_set_en", 32'(set_en), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_timeout", 32'(res_timeout), 32'd0);
    chk("rst_res_payload", 32'({res_candidate, res_tag, res_mode}), 32'd0);
    chk("rst_set_payload", 32'({set_central, set_radius, set_mode}), 32'd0);
    chk("rst_job_ready", 32'(job_ready), 32'd1);
    chk("rst_idle", 32'(idle), 32'd1);

    // Single job with fixed latency.
    stub_force = 1; stub_force_val = 8'd21; stub_delay = 20;
    push_ok(24'h334466, 12'h323, 2'b00, 6'd5);
    drain(200);
    chk("en_latency", 32'(en_cyc), 32'(push_cyc + 1));
    chk("res_latency", 32'(rise_cyc), 32'(vld_cyc + 1));
    chk("single_en_count", 32'(en_count), 32'd1);
    stub_force = 0;

    // Fill the FIFO while SET is busy.
    set_busy = 1'b1; res_ready = 1'b0;
    en_before = en_count;
    for (int i = 0; i < 4; i++)
      push_ok(24'($urandom), 12'($urandom), 2'($urandom), 6'(10 + i));
    @(negedge clk);
    chk("full_job_ready", 32'(job_ready), 32'd0);
    chk("full_idle", 32'(idle), 32'd0);
    push_job(24'h123456, 12'h789, 2'b11, 6'd14, 5, acc);
    chk("fifth_refused", 32'(acc), 32'd0);
    chk("busy_no_issue", 32'(en_count), 32'(en_before));
    set_busy = 1'b0; res_ready = 1'b1; stub_rand = 1;
    drain(800);
    stub_rand = 0;

    // Backpressure in RESULT with a second job waiting.
    res_ready = 1'b0; stub_delay = 3;
    push_ok(24'hABCDEF, 12'hFED, 2'b01, 6'd20);
    push_ok(24'h0F0F0F, 12'h0F0, 2'b10, 6'd21);
    for (int i = 0; i < 100 && !res_valid; i++) @(negedge clk);
    chk("bp_res_valid_seen", 32'(res_valid), 32'd1);
    en_before = en_count;
    repeat (10) @(negedge clk);
    chk("bp_no_second_en", 32'(en_count), 32'(en_before));
    @(posedge clk); #1 res_ready = 1'b1;
    drain(200);

    // Order and tags with random SET delays and random consumer stalls.
    stub_rand = 1; rr_rand = 1; cnt_before = res_count;
    for (int t = 0; t < 8; t++)
      push_ok(24'($urandom), 12'($urandom), 2'($urandom), 6'(t));
    drain(2000);
    rr_rand = 0; stub_rand = 0;
    @(posedge clk); #2 res_ready = 1'b1;
    chk("order_result_count", 32'(res_count - cnt_before), 32'd8);

    // Reset while one job waits on SET and two sit in the FIFO.
    stub_delay = 12;
    push_ok(24'h111111, 12'h111, 2'b00, 6'd30);
    push_ok(24'h222222, 12'h222, 2'b01, 6'd31);
    push_ok(24'h333333, 12'h333, 2'b10, 6'd32);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_idle", 32'(idle), 32'd1);
    chk("rst_mid_res_valid", 32'(res_valid), 32'd0);
    chk("rst_mid_job_ready", 32'(job_ready), 32'd1);
    late_bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (res_valid || set_en || !idle) late_bad++;
    end
    chk("late_set_valid_ignored", 32'(late_bad), 32'd0);
    stub_delay = 4;
    push_ok(24'h445566, 12'h778, 2'b11, 6'd33);
    drain(200);

`ifdef SEQ_TIMEOUT_EN
    // Watchdog: SET never answers.
    stub_never = 1;
    push_ok(24'h9ABCDE, 12'h456, 2'b10, 6'd40);
    drain(200);
    chk("timeout_latency", 32'(rise_cyc), 32'(en_cyc + 17));
    stub_never = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/set_job_sequencer.md
Name: set_job_sequencer

Overview:
- Upstream feeder for the SET circle-set candidate counter.
- Accepts (central, radius, mode, tag) jobs over a valid/ready interface and buffers them in a small FIFO.
- Issues jobs one at a time to SET using its en/busy/valid protocol, captures the candidate, and returns it tagged over a valid/ready result interface.
- Replaces the hand-timed stimulus loop so SET can sit inside a streaming datapath.

Parameters:
- DEPTH, 4, job FIFO entries; power of two, minimum 2.
- TAG_W, 6, width of the job tag carried through to the result.
- TIMEOUT_CYCLES, 4096, watchdog limit in WAIT; used only with SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- job_valid  in  1  job offered.
- job_ready  out  1  FIFO not full.
- job_central  in  24  {x1,y1,x2,y2,x3,y3}, 4 bits each.
- job_radius  in  12  {r1,r2,r3}, 4 bits each.
- job_mode  in  2  00 single / 01 union / 10 difference / 11 intersect.
- job_tag  in  TAG_W  caller identifier.
- set_en  out  1  one-cycle start pulse to SET.
- set_central  out  24  held stable from issue until result capture.
- set_radius  out  12  held stable from issue until result capture.
- set_mode  out  2  held stable from issue until result capture.
- set_busy  in  1  SET busy.
- set_valid  in  1  SET result strobe.
- set_candidate  in  8  SET result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts.
- res_candidate  out  8  captured candidate.
- res_tag  out  TAG_W  tag of the job.
- res_mode  out  2  mode of the job.
- res_timeout  out  1  watchdog abort flag; tied 0 without the feature.
- idle  out  1  FIFO empty and FSM in IDLE.

Behaviour:
- Reset (rst high at a clk edge):
  - Clears the FIFO and forces IDLE.
  - Outputs go to set_en=0, res_valid=0, res_timeout=0, res_candidate=0, res_tag=0, res_mode=0, set_central/radius/mode=0, job_ready=1, idle=1.
  - An in-flight job and any pending result are discarded. Reset mid-operation needs no recovery sequence.
- FIFO:
  - Push when job_valid && job_ready. job_ready = (count < DEPTH).
  - A push at full is refused; there is no bypass.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RESULT.
  - IDLE -> ISSUE when FIFO non-empty and set_busy==0. Pop the head into the set_* output registers.
  - ISSUE: set_en=1 for exactly this one cycle, then go to WAIT.
  - WAIT: on set_valid==1, capture set_candidate into res_candidate, then go to RESULT.
  - RESULT: res_valid=1. On res_ready, go to IDLE. res_valid must never drop without res_ready.
- Latency:
  - A job pushed at edge N into an empty FIFO with busy low reaches ISSUE at N+1 (set_en high during cycle N+1).
  - set_valid sampled at edge M gives res_valid high from M+1.
  - Back-to-back minimum: one IDLE cycle between jobs.
- set_valid outside WAIT is ignored.
- set_busy high in IDLE stalls issue indefinitely.
- set_central, set_radius and set_mode change only at pop.
- res_tag and res_mode come from the popped entry and stay stable through RESULT.
- Width rule: no arithmetic on the payload; fields pass through bit-exact.

Optional Feature:
- SEQ_TIMEOUT_EN defined:
  - A 16-bit counter is cleared on entering WAIT and increments each WAIT cycle.
  - Reaching TIMEOUT_CYCLES forces RESULT with res_timeout=1 and res_candidate=8'hFF.
  - set_valid arriving in the same cycle as the timeout takes priority (normal result, res_timeout=0).
- SEQ_TIMEOUT_EN undefined:
  - No counter is built; WAIT waits forever.
  - res_timeout is constant 0.

Decomposition:
- Shared package set_pkg holds:
  - mode constants MODE_SINGLE/MODE_UNION/MODE_DIFF/MODE_INTERSECT;
  - the central/radius field widths (4) and the packed job struct typedef;
  - the FSM state enum.
- One sub-module, set_job_fifo: parameterised synchronous FIFO with count.

Test Plan:
- Single job: push central=24'h334466, radius=12'h323, mode=00, tag=5. Stub SET asserts valid after 20 cycles with candidate=8'd21. Expect:
  - set_en pulses once, one cycle after the push;
  - res_valid the cycle after set_valid, with res_candidate=21, res_tag=5, res_mode=00.
- Fill FIFO: push 5 jobs with res_ready=0 and set_busy=1. Expect job_ready=0 after 4 pushes, the 5th held with no set_en, and idle=0.
- Backpressure: hold res_ready=0 for 10 cycles in RESULT. Expect res_valid and payload stable, and no second set_en until the handshake.
- Order and tags: stream tags 0..7 with random SET delays of 1..30 cycles. Expect results in tag order 0..7, with candidates matching the stub.
- Reset mid-WAIT: rst for 1 cycle while the FIFO holds 2 jobs. Expect:
  - the next cycle shows idle=1, res_valid=0, job_ready=1;
  - a late set_valid is ignored.
- SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=16 and the stub never asserting valid. Expect res_valid at 16 cycles after WAIT entry, with res_timeout=1 and res_candidate=8'hFF.
